// File: rtl/cd101_audio_pkg.sv
// Shared audio datapath definitions for the synthesis path and the 1-bit DAC.
package cd101_audio_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam logic [SAMPLE_W-1:0] SAMPLE_MIDSCALE = 16'h8000;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count; push ignored when full, pop when empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] COUNT_MAX = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == COUNT_MAX);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers are exactly log2(DEPTH) bits, so increment wraps naturally.
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: it is only read when count_q says an entry is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/dac_sample_pacer.sv
// Buffers producer samples and releases exactly one per sample period to the DAC modulator.
module dac_sample_pacer
    import cd101_audio_pkg::*;
#(
    parameter int unsigned          DIV          = 256,
    parameter int unsigned          DEPTH        = 4,
    parameter logic [SAMPLE_W-1:0]  RESET_SAMPLE = SAMPLE_MIDSCALE
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [SAMPLE_W-1:0]     s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic [SAMPLE_W-1:0]     dac_din,
    output logic                    sample_stb,
    output logic [$clog2(DEPTH):0]  fill,
    output logic                    underrun,
    input  logic                    clr_underrun
);

    localparam int unsigned CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                tick;
    logic                fifo_full, fifo_empty;
    logic [SAMPLE_W-1:0] fifo_head;
    logic                push, pop;
    logic [SAMPLE_W-1:0] dac_din_q, dac_din_d;
    logic                sample_stb_q;
    logic                underrun_q, underrun_d;

    assign tick    = en && (cnt_q == CNT_MAX);
    assign s_ready = !fifo_full;
    assign push    = s_valid && !fifo_full;
    assign pop     = tick && !fifo_empty;

    sync_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (s_data),
        .pop   (pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fill)
    );

    always_comb begin
        cnt_d      = '0;
        dac_din_d  = dac_din_q;
        underrun_d = underrun_q;
        if (en) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        end
        if (pop) begin
            dac_din_d = fifo_head;
        end
        // A starving tick outranks a simultaneous clear so the event is never lost.
        if (tick && fifo_empty) begin
            underrun_d = 1'b1;
        end else if (clr_underrun) begin
            underrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            dac_din_q    <= RESET_SAMPLE;
            sample_stb_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            dac_din_q    <= dac_din_d;
            sample_stb_q <= tick;
            underrun_q   <= underrun_d;
        end
    end

    assign dac_din    = dac_din_q;
    assign sample_stb = sample_stb_q;
    assign underrun   = underrun_q;

endmodule
